// File: rtl/mole_scheduler.sv
// mole_scheduler: Whack-A-Mole round sequencer. Lights one pseudo-random LED
// per round, scores hits, counts misses and shrinks the window after every hit.
module mole_scheduler #(
  parameter int unsigned UP_CYCLES     = 25_000_000,
  parameter int unsigned MIN_UP_CYCLES = 6_250_000,
  parameter int unsigned STEP_CYCLES   = 1_562_500,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned FLASH_CYCLES  = 6_250_000,
  parameter int unsigned BLINK_CYCLES  = 12_500_000,
  parameter int unsigned ROUNDS        = 20,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  input  logic [9:0] hit,
  output logic [9:0] LEDR,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic [7:0] round,
  output logic       busy,
  output logic       done
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max_u(max_u(UP_CYCLES, GAP_CYCLES),
                                          max_u(FLASH_CYCLES, BLINK_CYCLES));
  localparam int unsigned TW      = max_u(32'($clog2(MAX_CYC + 1)), 32'd26);

  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_CYCLES - 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_CYCLES - 1);
  localparam logic [32:0]   SHRINK_MIN = 33'(MIN_UP_CYCLES) + 33'(STEP_CYCLES);
  localparam logic [15:0]   LFSR_MASK  = 16'hB400;
  localparam logic [9:0]    LED_ALL    = 10'h3FF;
  localparam logic [9:0]    LED_END    = 10'h2AA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_FLASH,
    S_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [TW-1:0] window;
  logic [15:0]   lfsr;
  logic [3:0]    mole;

  logic [15:0]   lfsr_next_c;
  logic [3:0]    cand_c;
  logic [3:0]    mole_pick_c;
  logic [9:0]    mole_bit_c;
  logic          hit_ok_c;
  logic          hit_bad_c;
  logic          up_expire_c;
  logic          round_end_c;
  logic [7:0]    round_inc_c;
  logic          round_last_c;
  logic [TW-1:0] window_dec_c;
  logic [7:0]    score_inc_c;
  logic [7:0]    misses_inc_c;

  // Next LFSR value, mole choice, hit classification and round-end decode
  always_comb begin
    lfsr_next_c  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    cand_c       = 4'(lfsr % 16'd10);
    mole_pick_c  = cand_c;
    if (cand_c == mole) begin
      mole_pick_c = (cand_c == 4'd9) ? 4'd0 : cand_c + 4'd1;
    end
    mole_bit_c   = 10'(1) << mole;
    hit_ok_c     = (state == S_UP) && (hit == mole_bit_c);
    hit_bad_c    = (state == S_UP) && (hit != 10'd0) && !hit_ok_c;
    up_expire_c  = (state == S_UP) && (timer == window - TW'(1));
    round_end_c  = ((state == S_UP) && !hit_ok_c && (hit_bad_c || up_expire_c)) ||
                   ((state == S_FLASH) && (timer == FLASH_LAST));
    round_inc_c  = (round == 8'hFF) ? 8'hFF : round + 8'd1;
    round_last_c = (round_inc_c == 8'(ROUNDS));
    score_inc_c  = (score == 8'hFF) ? 8'hFF : score + 8'd1;
    misses_inc_c = (misses == 8'hFF) ? 8'hFF : misses + 8'd1;
    window_dec_c = (33'(window) >= SHRINK_MIN) ? window - TW'(STEP_CYCLES)
                                               : TW'(MIN_UP_CYCLES);
  end

  // Game FSM with registered LED drive, counters and status flags
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      timer  <= '0;
      window <= TW'(UP_CYCLES);
      lfsr   <= LFSR_SEED;
      mole   <= 4'd0;
      LEDR   <= 10'd0;
      score  <= 8'd0;
      misses <= 8'd0;
      round  <= 8'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      lfsr <= lfsr_next_c;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state  <= S_GAP;
            timer  <= '0;
            window <= TW'(UP_CYCLES);
            score  <= 8'd0;
            misses <= 8'd0;
            round  <= 8'd0;
            LEDR   <= 10'd0;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else if (state == S_DONE) begin
            if (timer == BLINK_LAST) begin
              timer <= '0;
              LEDR  <= ~LEDR;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            state <= S_UP;
            timer <= '0;
            mole  <= mole_pick_c;
            LEDR  <= 10'(1) << mole_pick_c;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_UP: begin
          if (hit_ok_c) begin
            state  <= S_FLASH;
            timer  <= '0;
            score  <= score_inc_c;
            window <= window_dec_c;
            LEDR   <= LED_ALL;
          end else if (hit_bad_c || up_expire_c) begin
            misses <= misses_inc_c;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_FLASH: begin
          timer <= timer + TW'(1);
        end
        default: begin
          state <= S_IDLE;
          LEDR  <= 10'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase

      // Round end overrides the per-state next values above
      if (round_end_c) begin
        round <= round_inc_c;
        timer <= '0;
        if (round_last_c) begin
          state <= S_DONE;
          LEDR  <= LED_END;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= S_GAP;
          LEDR  <= 10'd0;
        end
      end
    end
  end

endmodule
